systolic_seq_ctrl: RTL
======================

// Module: systolic_seq_ctrl
// PURPOSE
//  Sequencer for an ARRAY_DIM x ARRAY_DIM array of Q8.8 PEs.
//  Per job it runs four phases: load a weight tile into the PE inactive weight registers,
//  pulse switch to promote the tile, stream num_rows input vectors, then wait for all results.
//  Sits between the unified-buffer read ports and the PE array; drives the PE
//  accept_w / switch / valid / enabled controls. The datapath does not pass through it.
// PARAMETERS
//  ARRAY_DIM  2   PE rows = cols; number of weight rows per tile
//  ROWS_W     8   width of num_rows / row counters (max ROWS = 2**ROWS_W-1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  start          in   1       job request; sampled only in IDLE
//  num_rows       in   ROWS_W  input vectors in this job; latched on accepted start
//  abort          in   1       sync cancel; returns to IDLE next cycle, no done
//  w_src_valid    in   1       weight row available from buffer
//  w_src_ready    out  1       controller takes a weight row this cycle
//  x_src_valid    in   1       input vector available from buffer
//  x_src_ready    out  1       controller takes an input vector this cycle
//  res_valid_in   in   1       one result vector leaves the array bottom
//  pe_accept_w    out  1       to array: shift weight row into inactive regs
//  pe_switch      out  1       to array: swap inactive -> active weights
//  pe_valid       out  1       to array: input vector on pe_input_in is valid
//  pe_enabled     out  1       to array: PEs enabled
//  busy           out  1       high in every state except IDLE
//  done           out  1       1-cycle pulse, job completed
//  err            out  1       sticky: unexpected res_valid_in; cleared by rst or accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0. rst has priority over abort and start.
//  States: IDLE -> LOAD_W -> SWITCH -> STREAM -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 at edge k -> LOAD_W from cycle k+1; latch num_rows; clear err and counters.
//  LOAD_W: w_src_ready=1 and pe_enabled=1. w_fire = w_src_valid & w_src_ready.
//   pe_accept_w = w_fire (combinational, same cycle); pe_accept_w never pulses without a fire.
//   w_cnt increments on fire. After the fire that makes w_cnt == ARRAY_DIM -> SWITCH.
//   An invalid source stalls the phase indefinitely.
//  SWITCH: exactly one cycle with pe_switch=1 and all src readys=0.
//   If num_rows==0 -> DONE (weight preload only); otherwise -> STREAM.
//  STREAM: x_src_ready=1. x_fire -> pe_valid=1 in the same cycle, and x_cnt increments.
//   A bubble (x_src_valid=0) gives pe_valid=0, with no gap-filling.
//   After the fire that makes x_cnt == num_rows -> DRAIN; x_src_ready=0 from then on.
//  Result counter r_cnt: counts res_valid_in in STREAM and DRAIN.
//   res_valid_in in any other state, or once r_cnt==num_rows, sets err and does not count.
//  DRAIN: pe_enabled=1, no readys. r_cnt == num_rows -> DONE.
//   r_cnt may reach num_rows while still in STREAM; DRAIN then lasts exactly 1 cycle.
//  DONE: done=1 for one cycle; busy=1; -> IDLE. A start in DONE is ignored.
//  pe_enabled=1 in LOAD_W, SWITCH, STREAM and DRAIN; 0 in IDLE and DONE.
//  busy=1 whenever state != IDLE.
//  start while busy: ignored; does not queue.
//  abort in any non-IDLE state: next cycle state=IDLE, all outputs 0, done never pulses.
//   Array weight contents are not restored.
//  Counters are ROWS_W wide; w_cnt is $clog2(ARRAY_DIM+1) wide. No wrap: limits are checked with ==.
//  All outputs are combinational from state and current-cycle handshakes; no extra pipeline.
//  Minimum job latency with always-valid sources:
//   1 + ARRAY_DIM + 1 + num_rows + drain + 1 cycles from start to done.
// STRUCTURE
//  tpu_pkg: seq_state_t enum {IDLE,LOAD_W,SWITCH,STREAM,DRAIN,DONE};
//   DATA_W=16 and FRAC_BITS=8 (Q8.8), shared with pe and the buffers.
//  Single module: one state register, three counters, one output decode block.
//   No sub-module is warranted.
// TESTING
//  1 ARRAY_DIM=2, num_rows=3, sources always valid, res_valid_in 4 cycles after each pe_valid
//    -> accept_w high 2 cycles, then switch 1 cycle, then pe_valid 3 cycles, then done; err=0.
//  2 w_src_valid toggling 1,0,1 in LOAD_W -> pe_accept_w = 1,0,1; SWITCH entered only after the 2nd fire.
//  3 num_rows=0 -> 2 accept_w pulses, 1 switch, done on the next cycle, pe_valid never 1.
//  4 abort asserted mid-STREAM (x_cnt=1) -> next cycle busy=0, all outputs 0, no done;
//    a new start then works normally.
//  5 Extra res_valid_in after r_cnt==num_rows -> err=1 and stays 1 until the next accepted start.
//  6 start held high through a whole job -> the second job begins only after IDLE is re-entered;
//    no start is accepted while busy.

Source files
------------

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: Q8.8 datapath format and
// the sequencer state encoding.
package systolic_seq_ctrl_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned FRAC_BITS = 8;

   localparam int unsigned StateW = 3;
   typedef logic [StateW-1:0] seq_state_t;

   localparam seq_state_t StIdle   = 3'd0;
   localparam seq_state_t StLoadW  = 3'd1;
   localparam seq_state_t StSwitch = 3'd2;
   localparam seq_state_t StStream = 3'd3;
   localparam seq_state_t StDrain  = 3'd4;
   localparam seq_state_t StDone   = 3'd5;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Job control, buffer handshake and PE array control signals of the sequencer.
// The master side (job issuer / test harness) drives requests; the slave is the sequencer.
interface systolic_seq_ctrl_if #(
   parameter int unsigned ROWS_W = 8
);
   logic              start;
   logic [ROWS_W-1:0] num_rows;
   logic              abort;
   logic              w_src_valid;
   logic              w_src_ready;
   logic              x_src_valid;
   logic              x_src_ready;
   logic              res_valid_in;
   logic              pe_accept_w;
   logic              pe_switch;
   logic              pe_valid;
   logic              pe_enabled;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, num_rows, abort, w_src_valid, x_src_valid, res_valid_in,
      input  w_src_ready, x_src_ready, pe_accept_w, pe_switch, pe_valid, pe_enabled,
             busy, done, err
   );

   modport slave (
      input  start, num_rows, abort, w_src_valid, x_src_valid, res_valid_in,
      output w_src_ready, x_src_ready, pe_accept_w, pe_switch, pe_valid, pe_enabled,
             busy, done, err
   );

endinterface

// File: rtl/systolic_seq_ctrl.sv
// Per-job sequencer for an ARRAY_DIM x ARRAY_DIM systolic array: load weights, switch,
// stream input vectors, drain results. Controls only; no datapath passes through here.
module systolic_seq_ctrl
   import systolic_seq_ctrl_pkg::*;
#(
   parameter int unsigned ARRAY_DIM = 2,
   parameter int unsigned ROWS_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_seq_ctrl_if.slave   bus
);

   localparam int unsigned WCntW = $clog2(ARRAY_DIM + 1);
   localparam logic [WCntW-1:0] WLast = WCntW'(ARRAY_DIM);

   seq_state_t        r_state;
   seq_state_t        w_state_d;
   logic [WCntW-1:0]  r_w_cnt;
   logic [WCntW-1:0]  w_w_cnt_nxt;
   logic [ROWS_W-1:0] r_x_cnt;
   logic [ROWS_W-1:0] w_x_cnt_nxt;
   logic [ROWS_W-1:0] r_res_cnt;
   logic [ROWS_W-1:0] r_num_rows;
   logic              r_err;

   logic w_abort;
   logic w_start_acc;
   logic w_w_fire;
   logic w_x_fire;
   logic w_res_ok;
   logic w_res_bad;

   assign w_abort     = bus.abort & (r_state != StIdle);
   assign w_start_acc = bus.start & (r_state == StIdle);
   assign w_w_fire    = bus.w_src_valid & (r_state == StLoadW);
   assign w_x_fire    = bus.x_src_valid & (r_state == StStream);
   assign w_w_cnt_nxt = r_w_cnt + WCntW'(1);
   assign w_x_cnt_nxt = r_x_cnt + ROWS_W'(1);

   // Results only count while the job can still expect them; anything else is an error.
   assign w_res_ok  = bus.res_valid_in & ((r_state == StStream) | (r_state == StDrain)) &
                      (r_res_cnt != r_num_rows);
   assign w_res_bad = bus.res_valid_in & ~w_res_ok;

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:   if (bus.start) w_state_d = StLoadW;
         StLoadW:  if (w_w_fire && (w_w_cnt_nxt == WLast)) w_state_d = StSwitch;
         StSwitch: w_state_d = (r_num_rows == '0) ? StDone : StStream;
         StStream: if (w_x_fire && (w_x_cnt_nxt == r_num_rows)) w_state_d = StDrain;
         StDrain:  if (r_res_cnt == r_num_rows) w_state_d = StDone;
         StDone:   w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
      if (w_abort) w_state_d = StIdle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_w_cnt    <= '0;
         r_x_cnt    <= '0;
         r_res_cnt  <= '0;
         r_num_rows <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_abort) begin
            r_w_cnt   <= '0;
            r_x_cnt   <= '0;
            r_res_cnt <= '0;
            r_err     <= 1'b0;
         end else if (w_start_acc) begin
            r_num_rows <= bus.num_rows;
            r_w_cnt    <= '0;
            r_x_cnt    <= '0;
            r_res_cnt  <= '0;
            r_err      <= 1'b0;
         end else begin
            if (w_w_fire)  r_w_cnt   <= w_w_cnt_nxt;
            if (w_x_fire)  r_x_cnt   <= w_x_cnt_nxt;
            if (w_res_ok)  r_res_cnt <= r_res_cnt + ROWS_W'(1);
            if (w_res_bad) r_err     <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.w_src_ready = (r_state == StLoadW);
      bus.x_src_ready = (r_state == StStream);
      bus.pe_accept_w = w_w_fire;
      bus.pe_switch   = (r_state == StSwitch);
      bus.pe_valid    = w_x_fire;
      bus.pe_enabled  = (r_state == StLoadW) | (r_state == StSwitch) |
                        (r_state == StStream) | (r_state == StDrain);
      bus.busy        = (r_state != StIdle);
      bus.done        = (r_state == StDone);
      bus.err         = r_err;
   end

endmodule
